// File: rtl/hex_keypad.sv
// Scanned 4x4 hex keypad: synchronizes rows, debounces press/release, shifts codes into a 16-bit digit register.
// Latency: at most 4*SCAN_DIV + DEBOUNCE + 1 cycles after rs settles; no backpressure, key_valid is a one-cycle pulse.
module hex_keypad #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 20000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  rows,
   input  logic        clear,
   output logic [3:0]  cols,
   output logic [3:0]  key,
   output logic        key_valid,
   output logic        key_held,
   output logic [15:0] data
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } state_t;

   state_t        r_state;
   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [1:0]    r_col;
   logic [1:0]    r_row;
   logic [DW-1:0] r_div;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_cols;
   logic [3:0]    r_key;
   logic          r_key_valid;
   logic          r_key_held;
   logic [15:0]   r_data;

   logic          w_div_last;
   logic          w_cnt_last;
   logic          w_any_low;
   logic          w_row_low;
   logic [1:0]    w_first_row;
   logic [1:0]    w_col_next;
   logic [3:0]    w_cols_next;
   logic [3:0]    w_code;

   assign w_div_last  = (r_div == DW'(SCAN_DIV - 1));
   assign w_cnt_last  = (r_cnt == CW'(DEBOUNCE - 1));
   assign w_any_low   = (r_sync2 != 4'hF);
   assign w_row_low   = ~r_sync2[r_row];
   assign w_col_next  = r_col + 2'd1;
   assign w_cols_next = ~(4'b0001 << w_col_next);
   assign w_code      = {r_row, r_col};

   // Lowest-index active row wins when several keys share the column.
   always_comb begin
      w_first_row = 2'd3;
      if (!r_sync2[0])      w_first_row = 2'd0;
      else if (!r_sync2[1]) w_first_row = 2'd1;
      else if (!r_sync2[2]) w_first_row = 2'd2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 4'hF;
         r_sync2 <= 4'hF;
      end else begin
         r_sync1 <= rows;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_SCAN;
         r_col       <= 2'd0;
         r_row       <= 2'd0;
         r_cols      <= 4'b1110;
         r_div       <= '0;
         r_cnt       <= '0;
         r_key       <= 4'h0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
         r_data      <= 16'h0000;
      end else begin
         r_key_valid <= 1'b0;
         if (clear) r_data <= 16'h0000;

         case (r_state)
            ST_SCAN: begin
               if (w_div_last) begin
                  r_div <= '0;
                  if (w_any_low) begin
                     r_row   <= w_first_row;
                     r_cnt   <= '0;
                     r_state <= ST_DEBOUNCE;
                  end else begin
                     r_col  <= w_col_next;
                     r_cols <= w_cols_next;
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end

            ST_DEBOUNCE: begin
               if (w_row_low) begin
                  if (w_cnt_last) begin
                     r_key       <= w_code;
                     r_key_valid <= 1'b1;
                     r_key_held  <= 1'b1;
                     r_state     <= ST_HELD;
                     if (!clear) r_data <= {r_data[11:0], w_code};
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end else begin
                  r_state <= ST_SCAN;
                  r_div   <= '0;
                  r_col   <= w_col_next;
                  r_cols  <= w_cols_next;
               end
            end

            ST_HELD: begin
               if (!w_row_low) begin
                  r_state <= ST_RELEASE;
                  r_cnt   <= '0;
               end
            end

            ST_RELEASE: begin
               // A glitch back low resumes holding without a second accept.
               if (w_row_low) begin
                  r_state <= ST_HELD;
               end else if (w_cnt_last) begin
                  r_key_held <= 1'b0;
                  r_state    <= ST_SCAN;
                  r_div      <= '0;
                  r_col      <= w_col_next;
                  r_cols     <= w_cols_next;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: r_state <= ST_SCAN;
         endcase
      end
   end

   assign cols      = r_cols;
   assign key       = r_key;
   assign key_valid = r_key_valid;
   assign key_held  = r_key_held;
   assign data      = r_data;

endmodule

// File: tb/tb_hex_keypad.sv
// Bench for hex_keypad: a keypad matrix model drives rows from cols; accepts are
// predicted into a queue and a negedge monitor compares each key_valid pulse.
module tb_hex_keypad;

   localparam int SD      = 4;
   localparam int DB      = 8;
   localparam int LAT_MAX = 4*SD + DB + 1 + 3;

   typedef struct {
      logic [3:0]  key;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [3:0]  key;
   logic        key_valid;
   logic        key_held;
   logic [15:0] data;

   logic [15:0] pressed;
   logic [15:0] exp_data;
   logic        prev_valid;
   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;

   hex_keypad #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rows      (rows),
      .clear     (clear),
      .cols      (cols),
      .key       (key),
      .key_valid (key_valid),
      .key_held  (key_held),
      .data      (data)
   );

   always #5 clk = ~clk;

   // Matrix model: a pressed key at (r,c) pulls row r low while column c is driven.
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst !== 1'b0) begin
         prev_valid <= 1'b0;
      end else begin
         if (key_valid === 1'b1) begin
            check("valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_key_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("accept_key", {28'd0, key}, {28'd0, e.key});
               check("accept_data", {16'd0, data}, {16'd0, e.data});
               check("accept_held", {31'd0, key_held}, 32'd1);
            end
         end
         prev_valid <= key_valid;
      end
   end

   task automatic expect_key(input logic [3:0] code, input logic clr);
      exp_t e;
      exp_data = clr ? 16'h0000 : {exp_data[11:0], code};
      e.key  = code;
      e.data = exp_data;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string name);
      int n;
      for (n = 0; n < 80; n++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0) begin
         check({name, "_timeout"}, 32'd1, 32'd0);
         exp_q.delete();
      end else begin
         check({name, "_latency_ok"}, {31'd0, (n <= LAT_MAX)}, 32'd1);
      end
   endtask

   task automatic wait_release(input string name);
      int n;
      for (n = 0; n < 40; n++) begin
         if (key_held === 1'b0) break;
         @(negedge clk);
      end
      check({name, "_held_drops"}, {31'd0, key_held}, 32'd0);
   endtask

   task automatic do_key(input int r, input int c, input logic clr);
      logic [3:0] code;
      code = {r[1:0], c[1:0]};
      clear = clr;
      pressed[r*4+c] = 1'b1;
      expect_key(code, clr);
      wait_drain("seq_key");
      @(negedge clk);
      clear = 1'b0;
      pressed = 16'h0000;
      wait_release("seq_key");
   endtask

   initial begin
      logic [3:0] col_tbl [4];
      int         n;
      col_tbl[0] = 4'b1110; col_tbl[1] = 4'b1101;
      col_tbl[2] = 4'b1011; col_tbl[3] = 4'b0111;
      rst = 1'b1; clear = 1'b0; pressed = 16'h0000; exp_data = 16'h0000; prev_valid = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_cols", {28'd0, cols}, 32'h0000000E);
      check("rst_key", {28'd0, key}, 32'd0);
      check("rst_valid", {31'd0, key_valid}, 32'd0);
      check("rst_held", {31'd0, key_held}, 32'd0);
      check("rst_data", {16'd0, data}, 32'd0);

      // Idle scanning: one column per SD cycles, starting at column 0.
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("idle_cols", {28'd0, cols}, {28'd0, col_tbl[k]});
         repeat (SD) @(negedge clk);
      end

      // Row 2 / column 1, held stable.
      pressed[2*4+1] = 1'b1;
      expect_key(4'h9, 1'b0);
      wait_drain("key9");
      repeat (10) @(negedge clk);
      check("key9_key_holds", {28'd0, key}, 32'h9);
      check("key9_held", {31'd0, key_held}, 32'd1);
      check("key9_no_repeat", {31'd0, key_valid}, 32'd0);
      pressed = 16'h0000;
      repeat (4) @(negedge clk);
      check("key9_held_in_release", {31'd0, key_held}, 32'd1);
      wait_release("key9");
      check("key9_data", {16'd0, data}, 32'h0009);

      // Row 0 / column 3 with bounce while its column is being scanned.
      for (n = 0; n < 20; n++) begin
         if (cols == 4'b0111) break;
         @(negedge clk);
      end
      pressed[3] = 1'b1; repeat (3) @(negedge clk);
      pressed[3] = 1'b0; repeat (2) @(negedge clk);
      pressed[3] = 1'b1; @(negedge clk);
      pressed[3] = 1'b0; @(negedge clk);
      pressed[3] = 1'b1;
      expect_key(4'h3, 1'b0);
      wait_drain("bounce");
      pressed = 16'h0000;
      wait_release("bounce");

      // Keys 1..5 shift into the digit register.
      do_key(0, 1, 1'b0);
      do_key(0, 2, 1'b0);
      do_key(0, 3, 1'b0);
      do_key(1, 0, 1'b0);
      do_key(1, 1, 1'b0);
      check("seq_data_2345", {16'd0, data}, 32'h2345);

      // Sixth accept with clear held across it: clear wins, key still updates.
      do_key(1, 2, 1'b1);
      check("clear_data", {16'd0, data}, 32'h0000);
      check("clear_key", {28'd0, key}, 32'h6);

      // Rows 1 and 3 pressed together in column 2: row 1 wins.
      pressed[1*4+2] = 1'b1;
      pressed[3*4+2] = 1'b1;
      expect_key(4'h6, 1'b0);
      wait_drain("multi");
      repeat (3) @(negedge clk);
      check("multi_held", {31'd0, key_held}, 32'd1);
      check("multi_data", {16'd0, data}, 32'h0006);

      // Reset while HELD.
      rst = 1'b1;
      @(negedge clk);
      check("midheld_rst_cols", {28'd0, cols}, 32'h0000000E);
      check("midheld_rst_key", {28'd0, key}, 32'd0);
      check("midheld_rst_valid", {31'd0, key_valid}, 32'd0);
      check("midheld_rst_held", {31'd0, key_held}, 32'd0);
      check("midheld_rst_data", {16'd0, data}, 32'd0);
      pressed = 16'h0000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2 * 4 * SD) @(negedge clk);
      check("no_pending_accepts", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
